// File: rtl/mx_pkg.sv
// Shared encodings for the matrix execute stage: op codes, write-back selects,
// operand widths and FSM state constants.
package mx_pkg;

  typedef enum logic [1:0] {
    MX_TRANS = 2'b00,
    MX_VMUL  = 2'b01,
    MX_SCALE = 2'b10,
    MX_SUM   = 2'b11
  } mx_op_e;

  localparam logic [1:0] WSEL_NONE  = 2'b00;
  localparam logic [1:0] WSEL_REG   = 2'b01;
  localparam logic [1:0] WSEL_SLICE = 2'b10;
  localparam logic [1:0] WSEL_MAT   = 2'b11;

  localparam int ROW_W = 32;
  localparam int MAT_W = 128;

  typedef logic [1:0] mx_state_t;

  localparam mx_state_t ST_IDLE = 2'b00;
  localparam mx_state_t ST_BUSY = 2'b01;
  localparam mx_state_t ST_DONE = 2'b10;

endpackage

// File: rtl/mx_row_dp.sv
// Combinational per-row datapath: element products, the row dot-product byte
// and the row element sum.
module mx_row_dp
  import mx_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  input  logic [ROW_W-1:0] b_i,
  input  mx_op_e           op_i,
  output logic [ROW_W-1:0] prod_o,
  output logic [7:0]       dot_o,
  output logic [9:0]       sum_o
);

  // MSCALE multiplies every element by the scalar byte; otherwise element j pairs with B(j).
  always_comb begin
    prod_o = '0;
    dot_o  = '0;
    sum_o  = '0;
    for (int j = 0; j < 4; j++) begin
      prod_o[8*j +: 8] = row_i[8*j +: 8] *
                         ((op_i == MX_SCALE) ? b_i[7:0] : b_i[8*j +: 8]);
      dot_o = dot_o + prod_o[8*j +: 8];
      sum_o = sum_o + {2'b00, row_i[8*j +: 8]};
    end
  end

endmodule

// File: rtl/matrix_exec_unit.sv
// Multi-cycle matrix execute stage: latches one request, walks the four rows
// one per cycle, then holds the write-back bundle until it is accepted.
//
//   state | meaning
//   IDLE  | ready for a new request
//   BUSY  | processing row 0..3, one per cycle
//   DONE  | write-back bundle valid, waiting for out_ready_i
module matrix_exec_unit
  import mx_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int ELEM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [MAT_W-1:0] matrix_i,
  input  logic [ROW_W-1:0] operand_b_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       w_select_o,
  output logic [4:0]       w_regs_addr_o,
  output logic [ROW_W-1:0] w_regs_data_o,
  output logic [MAT_W-1:0] w_matrix_data_o
);

  localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

  mx_state_t        state;
  logic [1:0]       row;
  mx_op_e           op_q;
  logic [MAT_W-1:0] mat_q;
  logic [ROW_W-1:0] b_q;
  logic [4:0]       rd_q;
  logic [MAT_W-1:0] acc_mat;
  logic [ROW_W-1:0] acc_reg;

  logic [ROW_W-1:0] row_data;
  logic [ROW_W-1:0] row_prod;
  logic [7:0]       row_dot;
  logic [9:0]       row_sum;

  assign row_data = mat_q[{row, 5'b0} +: ROW_W];

  mx_row_dp u_row_dp (
    .row_i  (row_data),
    .b_i    (b_q),
    .op_i   (op_q),
    .prod_o (row_prod),
    .dot_o  (row_dot),
    .sum_o  (row_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      row     <= '0;
      op_q    <= MX_TRANS;
      mat_q   <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      acc_mat <= '0;
      acc_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i && !flush_i) begin
            op_q    <= mx_op_e'(op_i);
            mat_q   <= matrix_i;
            b_q     <= operand_b_i;
            rd_q    <= rd_i;
            acc_mat <= '0;
            acc_reg <= '0;
            row     <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            case (op_q)
              // Row k of the source becomes column k of the result.
              MX_TRANS: begin
                acc_mat[{2'd0, row, 3'd0} +: ELEM_W] <= row_data[7:0];
                acc_mat[{2'd1, row, 3'd0} +: ELEM_W] <= row_data[15:8];
                acc_mat[{2'd2, row, 3'd0} +: ELEM_W] <= row_data[23:16];
                acc_mat[{2'd3, row, 3'd0} +: ELEM_W] <= row_data[31:24];
              end
              MX_VMUL:  acc_reg[{row, 3'd0} +: ELEM_W] <= row_dot;
              MX_SCALE: acc_mat[{row, 5'd0} +: ROW_W]  <= row_prod;
              MX_SUM:   acc_reg <= acc_reg + {22'd0, row_sum};
            endcase
            row <= row + 2'd1;
            if (row == LAST_ROW) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush_i || out_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o      = (state == ST_IDLE);
    out_valid_o     = (state == ST_DONE);
    w_select_o      = WSEL_NONE;
    w_regs_addr_o   = '0;
    w_regs_data_o   = '0;
    w_matrix_data_o = '0;
    if (state == ST_DONE) begin
      w_regs_addr_o = rd_q;
      if (op_q == MX_TRANS || op_q == MX_SCALE) begin
        w_select_o      = WSEL_MAT;
        w_matrix_data_o = acc_mat;
      end else begin
        w_select_o    = WSEL_REG;
        w_regs_data_o = acc_reg;
      end
    end
  end

endmodule

// File: tb/tb_matrix_exec_unit.sv
// Bench for matrix_exec_unit: directed plan vectors plus randomized operations
// checked against an element-level reference model.
module tb_matrix_exec_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [1:0]   op_i;
  logic [127:0] matrix_i;
  logic [31:0]  operand_b_i;
  logic [4:0]   rd_i;
  logic         flush_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [1:0]   w_select_o;
  logic [4:0]   w_regs_addr_o;
  logic [31:0]  w_regs_data_o;
  logic [127:0] w_matrix_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] MAT_A = 128'h100f0e0d_0c0b0a09_08070605_04030201;

  matrix_exec_unit #(.ROWS(4), .ELEM_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .op_i            (op_i),
    .matrix_i        (matrix_i),
    .operand_b_i     (operand_b_i),
    .rd_i            (rd_i),
    .flush_i         (flush_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .w_select_o      (w_select_o),
    .w_regs_addr_o   (w_regs_addr_o),
    .w_regs_data_o   (w_regs_data_o),
    .w_matrix_data_o (w_matrix_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the whole operation computed at once from element arithmetic.
  function automatic void model(input logic [1:0] op, input logic [127:0] a,
                                input logic [31:0] b, output logic [31:0] data,
                                output logic [127:0] mat);
    int e [4][4];
    int bv [4];
    int acc;
    data = '0;
    mat  = '0;
    for (int k = 0; k < 4; k++) begin
      bv[k] = int'(b[8*k +: 8]);
      for (int j = 0; j < 4; j++) e[k][j] = int'(a[32*k + 8*j +: 8]);
    end
    case (op)
      2'b00: for (int k = 0; k < 4; k++)
               for (int j = 0; j < 4; j++) mat[32*j + 8*k +: 8] = 8'(e[k][j]);
      2'b01: for (int k = 0; k < 4; k++) begin
               acc = 0;
               for (int j = 0; j < 4; j++) acc += e[k][j] * bv[j];
               data[8*k +: 8] = 8'(acc % 256);
             end
      2'b10: for (int k = 0; k < 4; k++)
               for (int j = 0; j < 4; j++) mat[32*k + 8*j +: 8] = 8'((e[k][j] * bv[0]) % 256);
      default: begin
               acc = 0;
               for (int k = 0; k < 4; k++)
                 for (int j = 0; j < 4; j++) acc += e[k][j];
               data = 32'(acc);
             end
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready_o, 1'b1);
    chk({tag, "_out_valid"}, out_valid_o, 1'b0);
    chk({tag, "_wsel"}, w_select_o, 2'b00);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the handshake.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [127:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int hold,
                       input logic [31:0] exp_data, input logic [127:0] exp_mat);
    int n;
    logic [1:0] exp_sel;
    exp_sel = (op == 2'b00 || op == 2'b10) ? 2'b11 : 2'b01;
    chk({tag, "_ready_before"}, in_ready_o, 1'b1);
    in_valid_i  = 1'b1;
    op_i        = op;
    matrix_i    = a;
    operand_b_i = b;
    rd_i        = rd;
    out_ready_i = (hold == 0);
    @(negedge clk);
    in_valid_i  = 1'b0;
    op_i        = 2'($urandom);
    matrix_i    = {$urandom, $urandom, $urandom, $urandom};
    operand_b_i = $urandom;
    rd_i        = 5'($urandom);
    chk({tag, "_busy_ready"}, in_ready_o, 1'b0);
    n = 0;
    while (!out_valid_o && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_wsel"}, w_select_o, exp_sel);
    chk({tag, "_addr"}, w_regs_addr_o, rd);
    chk({tag, "_data"}, w_regs_data_o, exp_data);
    chk({tag, "_mat"}, w_matrix_data_o, exp_mat);
    chk({tag, "_done_ready"}, in_ready_o, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid_o, 1'b1);
      chk({tag, "_hold_data"}, w_regs_data_o, exp_data);
      chk({tag, "_hold_mat"}, w_matrix_data_o, exp_mat);
      chk({tag, "_hold_ready"}, in_ready_o, 1'b0);
      if (h == hold - 1) out_ready_i = 1'b1;
    end
    @(negedge clk);
    chk_idle({tag, "_after_hs"});
  endtask

  task automatic do_model_op(input string tag, input logic [1:0] op, input logic [127:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input int hold);
    logic [31:0]  d;
    logic [127:0] m;
    model(op, a, b, d, m);
    do_op(tag, op, a, b, rd, hold, d, m);
  endtask

  initial begin
    rst         = 1'b0;
    in_valid_i  = 1'b0;
    op_i        = '0;
    matrix_i    = '0;
    operand_b_i = '0;
    rd_i        = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_data", w_regs_data_o, 32'h0);
    chk("reset_mat", w_matrix_data_o, 128'h0);
    rst = 1'b1;
    @(negedge clk);

    do_op("mtrans", 2'b00, MAT_A, 32'h0, 5'd5, 0, 32'h0,
          128'h100c0804_0f0b0703_0e0a0602_0d090501);
    do_op("mvmul1", 2'b01, MAT_A, 32'h01010101, 5'd7, 0, 32'h3a2a1a0a, 128'h0);
    do_op("mvmul2", 2'b01, MAT_A, 32'h00000100, 5'd7, 0, 32'h0e0a0602, 128'h0);
    do_op("mscale2", 2'b10, MAT_A, 32'h00000002, 5'd1, 0, 32'h0,
          128'h201e1c1a_18161412_100e0c0a_08060402);
    do_model_op("mscaleff", 2'b10, MAT_A, 32'h000000ff, 5'd2, 0);
    do_op("msum1", 2'b11, MAT_A, 32'h0, 5'd0, 0, 32'h00000088, 128'h0);
    do_op("msum2", 2'b11, 128'hcccccccc_33333333_aaaaaaaa_55555555, 32'h0, 5'd9, 0,
          32'h000007f8, 128'h0);
    do_op("bp", 2'b01, MAT_A, 32'h01010101, 5'd3, 3, 32'h3a2a1a0a, 128'h0);
    do_op("bp_next", 2'b11, MAT_A, 32'h0, 5'd4, 0, 32'h00000088, 128'h0);

    // Flush on the second BUSY cycle.
    in_valid_i = 1'b1; op_i = 2'b00; matrix_i = MAT_A; rd_i = 5'd6;
    @(negedge clk);
    in_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk_idle("flush_busy");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_no_valid", out_valid_o, 1'b0);
    end

    // Flush in IDLE blocks a simultaneous request.
    in_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_ready", in_ready_o, 1'b1);
    repeat (5) @(negedge clk);
    chk("flush_idle_valid", out_valid_o, 1'b0);

    // Flush while DONE is stalled by backpressure.
    in_valid_i = 1'b1; op_i = 2'b11; out_ready_i = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("flush_done_pre", out_valid_o, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    chk_idle("flush_done");

    // Asynchronous reset in the middle of BUSY.
    in_valid_i = 1'b1; op_i = 2'b10; operand_b_i = 32'h3;
    @(negedge clk);
    in_valid_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_addr", w_regs_addr_o, 5'd0);
    chk("async_rst_data", w_regs_data_o, 32'h0);
    chk("async_rst_mat", w_matrix_data_o, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_valid", out_valid_o, 1'b0);
    do_op("post_rst_mtrans", 2'b00, MAT_A, 32'h0, 5'd5, 0, 32'h0,
          128'h100c0804_0f0b0703_0e0a0602_0d090501);

    for (int t = 0; t < 40; t++) begin
      do_model_op($sformatf("rnd%0d", t), 2'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, $urandom,
                  5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
